// File: rtl/tdm_demux.sv
// TDM frame demultiplexer: locks onto frame sync and splits each serial frame
// back into NUM_CH registered channel words with per-channel update strobes.
module tdm_demux #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    din,
  input  logic                    din_valid,
  input  logic                    fsync,
  output logic [NUM_CH*WIDTH-1:0] ch_data,
  output logic [NUM_CH-1:0]       ch_valid,
  output logic                    frame_done,
  output logic                    locked,
  output logic                    sync_err
);

  localparam int BW  = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int SW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SRW = (WIDTH  > 1) ? WIDTH - 1      : 1;

  typedef enum logic {HUNT, RECV} state_t;

  state_t                  state, state_n;
  logic [SRW-1:0]          shreg, shreg_n;
  logic [BW-1:0]           bitcnt, bitcnt_n, eff_bit;
  logic [SW-1:0]           slotcnt, slotcnt_n, eff_slot;
  logic [NUM_CH*WIDTH-1:0] ch_data_n;
  logic [NUM_CH-1:0]       ch_valid_n;
  logic                    frame_done_n, sync_err_n, take;
  logic [SRW:0]            cat;
  logic [WIDTH-1:0]        word;
  int                      slot_idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= HUNT;
      shreg      <= '0;
      bitcnt     <= '0;
      slotcnt    <= '0;
      ch_data    <= '0;
      ch_valid   <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      bitcnt     <= bitcnt_n;
      slotcnt    <= slotcnt_n;
      ch_data    <= ch_data_n;
      ch_valid   <= ch_valid_n;
      frame_done <= frame_done_n;
      sync_err   <= sync_err_n;
    end
  end

  // Counters both at zero while in RECV can only mean a frame just completed,
  // so that is where fsync is mandatory; a new frame is processed as bit 0 of slot 0.
  always_comb begin
    state_n      = state;
    shreg_n      = shreg;
    bitcnt_n     = bitcnt;
    slotcnt_n    = slotcnt;
    ch_data_n    = ch_data;
    ch_valid_n   = '0;
    frame_done_n = 1'b0;
    sync_err_n   = 1'b0;
    take         = 1'b0;
    eff_bit      = bitcnt;
    eff_slot     = slotcnt;
    cat          = {shreg, din};
    word         = cat[WIDTH-1:0];
    slot_idx     = 0;

    if (din_valid) begin
      if (state == HUNT) begin
        if (fsync) begin
          take     = 1'b1;
          eff_bit  = '0;
          eff_slot = '0;
          state_n  = RECV;
        end
      end else if (bitcnt == '0 && slotcnt == '0) begin
        if (fsync) begin
          take = 1'b1;
        end else begin
          sync_err_n = 1'b1;
          state_n    = HUNT;
        end
      end else if (fsync) begin
        sync_err_n = 1'b1;
        take       = 1'b1;
        eff_bit    = '0;
        eff_slot   = '0;
      end else begin
        take = 1'b1;
      end
    end

    if (take) begin
      shreg_n  = cat[SRW-1:0];
      slot_idx = int'(eff_slot);
      if (eff_bit == BW'(WIDTH - 1)) begin
        ch_data_n[slot_idx*WIDTH +: WIDTH] = word;
        ch_valid_n[eff_slot] = 1'b1;
        bitcnt_n = '0;
        if (eff_slot == SW'(NUM_CH - 1)) begin
          frame_done_n = 1'b1;
          slotcnt_n    = '0;
        end else begin
          slotcnt_n = eff_slot + SW'(1);
        end
      end else begin
        bitcnt_n  = eff_bit + BW'(1);
        slotcnt_n = eff_slot;
      end
    end
  end

  assign locked = (state == RECV);

endmodule

// File: tb/tb_tdm_demux.sv
// Randomized self-checking bench for tdm_demux against a frame-position
// reference model built from slot/frame arithmetic.
module tb_tdm_demux;

  localparam int N     = 4;
  localparam int W     = 8;
  localparam int FRAME = N * W;

  logic           clk = 1'b0;
  logic           rst_n, din, din_valid, fsync;
  logic [N*W-1:0] ch_data;
  logic [N-1:0]   ch_valid;
  logic           frame_done, locked, sync_err;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit       m_locked;
  int       m_pos;
  int       m_word;
  int       m_data [N];
  logic [N-1:0]   exp_valid;
  logic           exp_done, exp_err;
  logic [N*W-1:0] exp_data;

  bit gap_mode = 0;
  int gap_cnt  = 0;

  tdm_demux #(.NUM_CH(N), .WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .fsync      (fsync),
    .ch_data    (ch_data),
    .ch_valid   (ch_valid),
    .frame_done (frame_done),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic modelStep(input logic d, input logic v, input logic f, input logic r);
    bit take;
    int slot;
    exp_valid = '0;
    exp_done  = 1'b0;
    exp_err   = 1'b0;
    take      = 0;
    if (!r) begin
      m_locked = 0;
      m_pos    = 0;
      m_word   = 0;
      for (int k = 0; k < N; k++) m_data[k] = 0;
    end else if (v) begin
      if (!m_locked) begin
        if (f) begin
          m_locked = 1;
          m_pos    = 0;
          take     = 1;
        end
      end else if (m_pos == 0) begin
        if (f) take = 1;
        else begin
          exp_err  = 1'b1;
          m_locked = 0;
        end
      end else if (f) begin
        exp_err = 1'b1;
        m_pos   = 0;
        take    = 1;
      end else begin
        take = 1;
      end
      if (take) begin
        slot   = m_pos / W;
        m_word = (m_pos % W == 0) ? int'(d) : ((m_word * 2) + int'(d)) % (1 << W);
        m_pos++;
        if (m_pos % W == 0) begin
          m_data[slot]    = m_word;
          exp_valid[slot] = 1'b1;
          if (m_pos == FRAME) begin
            exp_done = 1'b1;
            m_pos    = 0;
          end
        end
      end
    end
    for (int k = 0; k < N; k++) exp_data[k*W +: W] = m_data[k][W-1:0];
  endtask

  task automatic applyStimulus(input logic d, input logic v, input logic f, input logic r);
    @(negedge clk);
    din       = d;
    din_valid = v;
    fsync     = f;
    rst_n     = r;
    modelStep(d, v, f, r);
    @(posedge clk);
    #1;
    checkOutput("ch_valid", 64'(ch_valid), 64'(exp_valid));
    checkOutput("frame_done", 64'(frame_done), 64'(exp_done));
    checkOutput("sync_err", 64'(sync_err), 64'(exp_err));
    checkOutput("locked", 64'(locked), 64'(m_locked));
    checkOutput("ch_data", 64'(ch_data), 64'(exp_data));
  endtask

  task automatic sendBit(input logic d, input logic f);
    applyStimulus(d, 1'b1, f, 1'b1);
    if (gap_mode) begin
      gap_cnt++;
      if (gap_cnt % 5 == 0)
        for (int i = 0; i < 3; i++) applyStimulus($urandom_range(0, 1), 1'b0, $urandom_range(0, 1), 1'b1);
    end
  endtask

  // Slot k occupies words[k*W +: W]; each slot goes out MSB first.
  task automatic sendFrame(input logic [N*W-1:0] words, input logic first_fsync);
    logic [N*W-1:0] wv;
    wv = words;
    for (int k = 0; k < N; k++)
      for (int b = W - 1; b >= 0; b--)
        sendBit(wv[k*W + b], (k == 0 && b == W - 1) ? first_fsync : 1'b0);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [N*W-1:0] w;
    din = 0; din_valid = 0; fsync = 0; rst_n = 0;

    doReset();
    checkOutput("reset_data", 64'(ch_data), 64'h0);
    checkOutput("reset_locked", 64'(locked), 64'h0);
    sendFrame(32'h00FF3CA5, 1'b1);
    checkOutput("basic_data", 64'(ch_data), 64'h00FF3CA5);

    doReset();
    gap_mode = 1;
    gap_cnt  = 0;
    sendFrame(32'h00FF3CA5, 1'b1);
    gap_mode = 0;
    checkOutput("gapped_data", 64'(ch_data), 64'h00FF3CA5);

    sendFrame(32'($urandom), 1'b1);
    sendFrame(32'($urandom), 1'b1);
    sendFrame(32'($urandom), 1'b0);
    checkOutput("miss_locked", 64'(locked), 64'h0);
    w = 32'($urandom);
    w[7:0] = 8'h11;
    sendFrame(w, 1'b1);
    checkOutput("miss_slice0", 64'(ch_data[7:0]), 64'h11);

    w = 32'($urandom);
    for (int i = 0; i < 2 * W + 3; i++) sendBit(w[(i / W) * W + (W - 1 - i % W)], i == 0);
    sendFrame(32'h78563412, 1'b1);
    checkOutput("early_data", 64'(ch_data), 64'h78563412);

    w = 32'($urandom);
    for (int i = 0; i < W + 4; i++) sendBit(w[(i / W) * W + (W - 1 - i % W)], i == 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("midrst_data", 64'(ch_data), 64'h0);
    checkOutput("midrst_locked", 64'(locked), 64'h0);
    sendFrame(32'h04030201, 1'b1);
    checkOutput("midrst_frame", 64'(ch_data), 64'h04030201);

    doReset();
    for (int i = 0; i < 20; i++) sendBit($urandom_range(0, 1), 1'b0);
    checkOutput("idle_locked", 64'(locked), 64'h0);
    sendFrame(32'($urandom), 1'b1);

    for (int i = 0; i < 3000; i++) begin
      logic v, f;
      v = ($urandom_range(0, 3) != 0);
      f = (m_locked && m_pos == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 49) == 0);
      applyStimulus($urandom_range(0, 1), v, f, $urandom_range(0, 499) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
Receive-side counterpart of the team's channel multiplexer. It accepts a time-division-multiplexed serial bit stream with a frame-sync marker and splits each frame back into NUM_CH parallel channel words. The block locks onto frame sync and emits a one-cycle strobe for each recovered channel. It sits at the far end of the TDM link, after the line and before the per-channel consumers.

Parameters:
NUM_CH, 4, number of channel slots per frame (>=2)
WIDTH, 8, bits per slot; frame length = NUM_CH*WIDTH valid bits

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset
din  input  1  serial data bit, MSB of each slot first
din_valid  input  1  din/fsync are sampled only when high
fsync  input  1  high with bit 0 of slot 0 of every frame
ch_data  output  NUM_CH*WIDTH  registered channel words; channel k at [k*WIDTH +: WIDTH]
ch_valid  output  NUM_CH  one-cycle strobe, bit k = channel k updated
frame_done  output  1  one-cycle strobe, coincident with the last slot's ch_valid
locked  output  1  high while in RECV
sync_err  output  1  one-cycle strobe on a framing violation

Behaviour:
- Reset: rst_n low at a clock edge clears all outputs to 0, clears the shift register and bit/slot counters, and sets state to HUNT. Reset mid-frame discards the partial slot.
- Only cycles with din_valid=1 count as bit times. With din_valid=0, counters, shift register and state hold, and fsync is ignored. Strobes are never extended by idle cycles.
- State HUNT:
  - Valid bit with fsync=1: accept it as bit 0 of slot 0, move to RECV.
  - Valid bit with fsync=0: discard it.
  - locked=0.
- State RECV:
  - Shift din into the slot shift register, MSB first.
  - Bit counter runs 0..WIDTH-1; slot counter runs 0..NUM_CH-1.
- Slot completion: on the edge sampling bit WIDTH-1 of slot k, ch_data slice k is loaded with the full word. ch_valid[k]=1 for the following cycle only. Other slices hold their value.
- Frame completion: when slot NUM_CH-1 completes, frame_done=1 in the same cycle as ch_valid[NUM_CH-1]. The counters wrap to 0 and the state stays RECV.
- Expected frame start in RECV (next valid bit after a completed frame):
  - fsync=1: continue normally.
  - fsync=0: drop that bit, pulse sync_err next cycle, go to HUNT (locked falls next cycle).
- Early fsync (fsync=1 on any valid bit other than an expected frame start):
  - Pulse sync_err next cycle and abandon the partial slot with no ch_valid for it.
  - Treat the current bit as bit 0 of slot 0 of a new frame and stay in RECV.
  - Completed slices from the abandoned frame keep their value.
- Latency: a slot's last valid bit leads to ch_valid one cycle later; a violating bit leads to sync_err one cycle later.
- Simultaneous events: the last bit of the last slot produces both ch_valid[NUM_CH-1] and frame_done. If fsync is high on that last bit, it is an early fsync: sync_err fires, no ch_valid or frame_done fires, and the bit starts a new frame.
- Counter widths: clog2(WIDTH) and clog2(NUM_CH), minimum 1. Counters wrap exactly at WIDTH-1 and NUM_CH-1, never at a power-of-two boundary.

Test Plan:
1. Basic frame (NUM_CH=4, WIDTH=8): reset, then send one frame with slots 0xA5, 0x3C, 0xFF, 0x00, din_valid=1 continuously, fsync on the first bit. Required: ch_valid pulses 0001, 0010, 0100, 1000, each 8 cycles apart; frame_done with the last pulse; final ch_data=0x00FF3CA5; locked=1 from the second bit.
2. Gapped stream: same frame with din_valid low for 3 cycles after every 5th bit. Required: identical ch_data; strobes still exactly one cycle wide; no sync_err.
3. Missing fsync: two good frames, then a third frame starting with fsync=0. Required: sync_err one cycle after that bit; locked=0; no ch_valid until the next fsync. Then send a frame with slot 0 = 0x11. Required: ch_valid[0] pulses and slice 0 reads 0x11.
4. Early fsync: fsync=1 at bit 3 of slot 2. Required: sync_err pulse; no ch_valid[2]; the next 32 valid bits from that point decode as a full frame.
5. Reset mid-frame: rst_n low for 1 cycle during slot 1. Required: all outputs 0 next cycle and state HUNT. Send a fresh frame 0x01, 0x02, 0x03, 0x04. Required: ch_data=0x04030201.
6. Idle before lock: 20 valid bits with fsync=0, then a good frame. Required: no strobes, no sync_err, locked=0 until that frame's fsync.
